// File: rtl/flex_counter_pkg.sv
// flex_counter_pkg: shared direction encoding and terminal-value helper for the flex counter channels.
package flex_counter_pkg;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  localparam int MAX_W = 32;
  function automatic logic [MAX_W-1:0] terminal_val(input logic dir, input logic [MAX_W-1:0] rollover_val);
    return dir == DIR_UP ? rollover_val : MAX_W'(1);
  endfunction
endpackage

// File: rtl/flex_counter_multi_if.sv
// flex_counter_multi_if: control and status bundle for the multi-channel flex counter.
interface flex_counter_multi_if #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] clear, load, count_enable, count_up, rollover_flag, wrap_pulse;
  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val, rollover_val, count_out;
  modport master (
    output clear, load, load_val, count_enable, count_up, rollover_val,
    input count_out, rollover_flag, wrap_pulse
  );
  modport slave (
    input clear, load, load_val, count_enable, count_up, rollover_val,
    output count_out, rollover_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_counter_ch.sv
// flex_counter_ch: one programmable up/down counter channel with external advance and combinational wrap event.
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic adv,
  input  logic count_up,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic rollover_flag,
  output logic wrap_pulse,
  output logic wrap_evt
);
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);
  logic [NUM_CNT_BITS-1:0] nxt, term;
  logic hit, live;
  always_comb begin
    live = rollover_val != '0;
    term = NUM_CNT_BITS'(terminal_val(count_up, MAX_W'(rollover_val)));
    hit = count_up == DIR_UP ? count_out >= rollover_val : count_out == ONE;
    wrap_evt = adv && !clear && !load && live && hit;
    nxt = !live ? '0
        : count_up == DIR_UP ? (hit ? ONE : count_out + ONE)
        : (count_out <= ONE || count_out > rollover_val) ? rollover_val : count_out - ONE;
  end
  // A rollover_val of zero disables the channel, so its flag never asserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap_evt;
      if (clear) begin
        count_out <= '0;
        rollover_flag <= 1'b0;
      end else if (load) begin
        count_out <= load_val;
        rollover_flag <= live && load_val == term;
      end else if (adv) begin
        count_out <= nxt;
        rollover_flag <= live && nxt == term;
      end
    end
  end
endmodule

// File: rtl/flex_counter_multi.sv
// flex_counter_multi: NUM_CH independent flex counters, optionally cascaded into one prescaled chain.
module flex_counter_multi #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH = 2,
  parameter bit CASCADE = 1'b0
) (
  input logic clk,
  input logic rst,
  flex_counter_multi_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic adv, evt;
    if (CASCADE == 1'b0 || i == 0) begin : g_root
      assign adv = bus.count_enable[i];
    end else begin : g_chain
      assign adv = bus.count_enable[i] && g_ch[i-1].evt;
    end
    flex_counter_ch #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_ch (
      .clk(clk),
      .rst(rst),
      .clear(bus.clear[i]),
      .load(bus.load[i]),
      .adv(adv),
      .count_up(bus.count_up[i]),
      .load_val(bus.load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_val(bus.rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count_out(bus.count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag(bus.rollover_flag[i]),
      .wrap_pulse(bus.wrap_pulse[i]),
      .wrap_evt(evt)
    );
  end
endmodule

// File: doc/flex_counter_multi.md
# flex_counter_multi

Parametrised multi-channel successor to the single-channel flex counter. Provides NUM_CH independent counters with per-channel rollover value, up/down direction, synchronous load and clear, and an optional cascade mode that chains channels into one wide prescaled counter. It serves timing and baud-divider logic that needs several programmable dividers, or one multi-stage divider, from a single instance.

## Interface
Parameters:
- NUM_CNT_BITS, 4: width of each channel's counter.
- NUM_CH, 2: number of channels, at least 1.
- CASCADE, 0: when 1, channel i>0 advances only on channel i-1's wrap event.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- clear  in  NUM_CH  per-channel synchronous clear.
- load  in  NUM_CH  per-channel synchronous load.
- load_val  in  NUM_CH*NUM_CNT_BITS  load values; channel i occupies bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
- count_enable  in  NUM_CH  per-channel enable.
- count_up  in  NUM_CH  direction: 1 selects up, 0 selects down.
- rollover_val  in  NUM_CH*NUM_CNT_BITS  per-channel terminal value, packed the same way as load_val.
- count_out  out  NUM_CH*NUM_CNT_BITS  per-channel count, packed the same way.
- rollover_flag  out  NUM_CH  registered; high while the channel count equals its terminal value.
- wrap_pulse  out  NUM_CH  registered; high for one cycle after a wrap event.

## Operation
- Per-channel priority: rst, then clear, then load, then advance, then hold.
- rst forces count_out = 0, rollover_flag = 0 and wrap_pulse = 0 on all channels, immediately and asynchronously.
- clear sets count to 0 and rollover_flag to 0.
- load sets count to load_val.
- Advance condition: adv[i] = count_enable[i] && (CASCADE==0 || i==0 || wrap_evt[i-1]). wrap_evt is combinational and equals the channel's own advance-and-wrap condition.
- Up mode:
  - If count >= rollover_val, next count = 1 and wrap_evt = 1.
  - Otherwise next count = count + 1.
  - Counting sequence: 1 .. rollover_val, repeating.
- Down mode:
  - If count <= 1 or count > rollover_val, next count = rollover_val.
  - wrap_evt = 1 only when count == 1.
  - Starting from 0, the first advance loads rollover_val with no wrap.
- Terminal value: rollover_val in up mode, 1 in down mode.
- rollover_flag is registered as (next count == terminal), evaluated in every cycle the count register updates: clear, load or advance.
- A direction change takes effect on the next advance. rollover_flag is re-evaluated only when the count updates.
- wrap_pulse[i] is the registered wrap_evt[i]. A clear or load in the same cycle suppresses the event.
- rollover_val == 0 means the channel is disabled. On advance, count is forced to 0, rollover_flag = 0 and no wrap event occurs.
- All arithmetic is NUM_CNT_BITS wide, unsigned and non-saturating. The >= comparison prevents runaway past the terminal when rollover_val is lowered mid-count.
- Cascade:
  - A clear or load on channel i-1 blocks channel i's advance in that cycle.
  - Channel i's own clear or load takes priority over its cascaded advance.

## Timing
- Every output is registered and changes one cycle after the causing input edge. The exception is the asynchronous reset assertion.
- Cascade ripple is combinational within the cycle. All channels update on the same edge, so channel i-1's wrap and channel i's increment coincide.
- Reset deassertion mid-operation: the first edge after release applies normal priority.
- Critical path: NUM_CH chained compare plus AND in cascade mode.

## Structure
- Package flex_counter_pkg holds:
  - localparam DIR_DOWN = 1'b0 and DIR_UP = 1'b1;
  - a helper function computing a channel's terminal value from direction and rollover_val.
- Sub-module flex_counter_ch implements one channel with the same ports, scalar widths and an external adv input. It returns wrap_evt combinationally.
- The top level is a generate loop over NUM_CH plus the cascade enable wiring.

## Test plan
- Reset and up count: NUM_CNT_BITS=4, rollover_val=5, up, enable held. Required: count 0,1,2,3,4,5,1,2. rollover_flag high during the cycles count=5. wrap_pulse high during the cycle count returns to 1. Assert rst mid-count, and all outputs read 0 with no clock edge.
- Down count: rollover_val=3, down, starting from 0. Required: count 3,2,1,3,2,1. rollover_flag high while count=1. wrap_pulse follows each 1->3 transition.
- Priority: clear, load and enable all asserted together, with load_val=7, gives count=0. Load plus enable gives count=7 on the next cycle. Then set rollover_val=4: the next advance gives count=1 with a wrap_pulse.
- Disabled channel: rollover_val=0 with enable gives count held at 0, rollover_flag=0 and wrap_pulse=0 indefinitely.
- Cascade: CASCADE=1, NUM_CH=2, both rollover_val=3, both up, both enabled. Required: ch1 increments once per three ch0 advances. ch1 wraps 3->1 after nine ch0 advances, with wrap_pulse[1] coinciding with wrap_pulse[0].
- Cascade blocking: ch0 at count 3 with clear[0] asserted. Required: ch0 goes to 0, ch1 holds, and no wrap pulse on either channel.
